// File: rtl/sequenciador_dampers.sv
// sequenciador_dampers: round-robin pressure-order checker for the six
// ventilation damper pairs. An inverted pair gets its damper opened alone for
// a settle window and is re-checked; a persistent inversion latches an alarm
// until acknowledged. Damper outputs are a Moore decode of state and idx, so
// at most one damper can be open.
module sequenciador_dampers #(
  parameter int SETTLE_CYC = 8,
  parameter int MAX_TRIES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [3:0] sensPresSC,
  input  logic signed [3:0] sensPresS1,
  input  logic signed [3:0] sensPresS2,
  input  logic signed [3:0] sensPresS3,
  input  logic signed [3:0] sensPresTubSR,
  input  logic signed [3:0] sensPresTubSS,
  input  logic signed [3:0] sensPresRea,
  input  logic              ackAlarme,
  output logic              damperRSR,
  output logic              damperS3SR,
  output logic              damperS23,
  output logic              damperS12,
  output logic              damperS3SS,
  output logic              damperSSSC,
  output logic              alarmeSonoroVentilacao,
  output logic [2:0]        falhaIdx,
  output logic              ocupado
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TMR_LOAD  = TW'(SETTLE_CYC - 1);
  localparam logic [2:0]    TRIES_MAX = 3'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [2:0]      r_idx, w_idx;
  logic [2:0]      r_tries, w_tries;
  logic [TW-1:0]   r_timer, w_timer;
  logic [2:0]      r_falha, w_falha;

  logic signed [3:0] w_src, w_dst;
  logic              w_inv;
  logic [2:0]        w_idx_inc;
  logic [2:0]        w_falha_inc;
  logic [5:0]        w_dmp;

  // Select the source/destination pressures of the pair under test
  always_comb begin
    w_src = 4'sd0;
    w_dst = 4'sd0;
    case (r_idx)
      3'd0: begin w_src = sensPresTubSR; w_dst = sensPresRea;   end
      3'd1: begin w_src = sensPresS3;    w_dst = sensPresTubSR; end
      3'd2: begin w_src = sensPresS2;    w_dst = sensPresS3;    end
      3'd3: begin w_src = sensPresS1;    w_dst = sensPresS2;    end
      3'd4: begin w_src = sensPresTubSS; w_dst = sensPresS3;    end
      3'd5: begin w_src = sensPresSC;    w_dst = sensPresTubSS; end
      default: begin w_src = 4'sd0;      w_dst = 4'sd0;         end
    endcase
  end

  // Both operands are signed 4-bit, so -8 < 7 compares correctly; equal is an inversion
  assign w_inv       = (w_dst >= w_src);
  assign w_idx_inc   = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
  assign w_falha_inc = (r_falha == 3'd5) ? 3'd0 : r_falha + 3'd1;

  // Next-state logic for the scan / open / check / alarm sequence
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_tries = r_tries;
    w_timer = r_timer;
    w_falha = r_falha;
    case (r_state)
      ST_SCAN: begin
        if (w_inv) begin
          w_state = ST_OPEN;
          w_tries = 3'd1;
          w_timer = TMR_LOAD;
        end else begin
          w_idx = w_idx_inc;
        end
      end
      ST_OPEN: begin
        if (r_timer == '0) w_state = ST_CHECK;
        else               w_timer = r_timer - 1'b1;
      end
      ST_CHECK: begin
        if (!w_inv) begin
          w_state = ST_SCAN;
          w_idx   = w_idx_inc;
          w_tries = 3'd0;
        end else if (r_tries < TRIES_MAX) begin
          w_state = ST_OPEN;
          w_tries = r_tries + 3'd1;
          w_timer = TMR_LOAD;
        end else begin
          w_state = ST_ALARM;
          w_falha = r_idx;
        end
      end
      ST_ALARM: begin
        if (ackAlarme) begin
          w_state = ST_SCAN;
          w_idx   = w_falha_inc;
          w_tries = 3'd0;
        end
      end
      default: w_state = ST_SCAN;
    endcase
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SCAN;
      r_idx   <= 3'd0;
      r_tries <= 3'd0;
      r_timer <= '0;
      r_falha <= 3'd0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_tries <= w_tries;
      r_timer <= w_timer;
      r_falha <= w_falha;
    end
  end

  // Moore output decode: one damper, selected by idx, while opening or checking
  always_comb begin
    ocupado = (r_state == ST_OPEN) || (r_state == ST_CHECK);
    w_dmp   = ocupado ? (6'd1 << r_idx) : 6'd0;
  end

  assign damperRSR              = w_dmp[0];
  assign damperS3SR             = w_dmp[1];
  assign damperS23              = w_dmp[2];
  assign damperS12              = w_dmp[3];
  assign damperS3SS             = w_dmp[4];
  assign damperSSSC             = w_dmp[5];
  assign alarmeSonoroVentilacao = (r_state == ST_ALARM);
  assign falhaIdx               = r_falha;

endmodule

// File: tb/tb_sequenciador_dampers.sv
// Directed bench for sequenciador_dampers with hand-computed expectations.
module tb_sequenciador_dampers;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [3:0] sc, s1, s2, s3, tsr, tss, rea;
  logic              ack;
  logic              dRSR, dS3SR, dS23, dS12, dS3SS, dSSSC;
  logic              alarm, ocup;
  logic [2:0]        falha;
  logic [5:0]        dmp;

  int n_run  = 0;
  int n_fail = 0;

  sequenciador_dampers #(.SETTLE_CYC(8), .MAX_TRIES(3)) dut (
    .clk(clk), .rst(rst),
    .sensPresSC(sc), .sensPresS1(s1), .sensPresS2(s2), .sensPresS3(s3),
    .sensPresTubSR(tsr), .sensPresTubSS(tss), .sensPresRea(rea),
    .ackAlarme(ack),
    .damperRSR(dRSR), .damperS3SR(dS3SR), .damperS23(dS23), .damperS12(dS12),
    .damperS3SS(dS3SS), .damperSSSC(dSSSC),
    .alarmeSonoroVentilacao(alarm), .falhaIdx(falha), .ocupado(ocup)
  );

  always #5 clk = ~clk;

  // bit k of dmp is the damper of pair k
  assign dmp = {dSSSC, dS3SS, dS12, dS23, dS3SR, dRSR};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic healthy;
    sc = 4'sd2; s1 = 4'sd0; s2 = -4'sd1; s3 = -4'sd3;
    tss = -4'sd2; tsr = -4'sd5; rea = -4'sd7;
  endtask

  // Holds reset for two edges; the next tick is the first scanning edge (idx 0)
  task automatic do_reset;
    rst = 1'b1; ack = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    healthy;
    rst = 1'b1; ack = 1'b0;
    tick; tick;
    n_run++; if (dmp !== 6'd0)  begin n_fail++; $display("FAIL reset_dampers got=%b exp=000000", dmp); end
    n_run++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    n_run++; if (falha !== 3'd0) begin n_fail++; $display("FAIL reset_falha got=%0d exp=0", falha); end
    n_run++; if (ocup !== 1'b0)  begin n_fail++; $display("FAIL reset_ocupado got=%b exp=0", ocup); end
    rst = 1'b0;
  endtask

  task automatic test_healthy;
    do_reset; healthy;
    for (int k = 0; k < 12; k++) begin
      ack = (k == 5);
      tick;
      n_run++; if (dmp !== 6'd0 || ocup !== 1'b0 || alarm !== 1'b0) begin
        n_fail++; $display("FAIL healthy_idle cyc=%0d dmp=%b ocup=%b alarm=%b exp=000000/0/0", k, dmp, ocup, alarm);
      end
    end
    ack = 1'b0;
    // idx is back at 0 after 12 scans; invert pair 2 and expect it exactly 3 edges later
    s2 = -4'sd3;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_run++; if (dmp !== ((k == 2) ? 6'b000100 : 6'b000000)) begin
        n_fail++; $display("FAIL healthy_idx_wrap step=%0d got=%b exp=%b", k, dmp, (k == 2) ? 6'b000100 : 6'b000000);
      end
    end
  endtask

  task automatic test_rsr_resolve;
    do_reset; healthy;
    rea = -4'sd1; tsr = -4'sd2;   // pair 0 inverted; pair 1 also inverted (-2 >= -3)
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) rea = -4'sd3;   // fixed mid-OPEN; only seen by the CHECK
      tick;
      n_run++; if (dmp !== 6'b000001 || alarm !== 1'b0) begin
        n_fail++; $display("FAIL rsr_open cyc=%0d dmp=%b alarm=%b exp=000001/0", k, dmp, alarm);
      end
    end
    tick;
    n_run++; if (dmp !== 6'd0 || ocup !== 1'b0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL rsr_drop dmp=%b ocup=%b alarm=%b exp=000000/0/0", dmp, ocup, alarm);
    end
    tick;
    n_run++; if (dmp !== 6'b000010) begin
      n_fail++; $display("FAIL rsr_next_pair got=%b exp=000010", dmp);
    end
  endtask

  task automatic test_alarm;
    do_reset; healthy;
    s2 = -4'sd1; s3 = -4'sd1;     // pair 2 equal -> inverted
    for (int k = 0; k < 2; k++) begin
      tick;
      n_run++; if (dmp !== 6'd0) begin n_fail++; $display("FAIL alarm_prescan cyc=%0d got=%b exp=000000", k, dmp); end
    end
    for (int k = 1; k <= 27; k++) begin
      ack = (k == 5);             // ignored while OPEN
      tick;
      n_run++; if (dmp !== 6'b000100 || alarm !== 1'b0) begin
        n_fail++; $display("FAIL alarm_open cyc=%0d dmp=%b alarm=%b exp=000100/0", k, dmp, alarm);
      end
    end
    ack = 1'b0;
    tick;
    n_run++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_rise got=%b exp=1", alarm); end
    n_run++; if (falha !== 3'd2) begin n_fail++; $display("FAIL alarm_falha got=%0d exp=2", falha); end
    n_run++; if (dmp !== 6'd0 || ocup !== 1'b0) begin
      n_fail++; $display("FAIL alarm_closed dmp=%b ocup=%b exp=000000/0", dmp, ocup);
    end
    tick;
    n_run++; if (alarm !== 1'b1 || falha !== 3'd2) begin
      n_fail++; $display("FAIL alarm_hold alarm=%b falha=%0d exp=1/2", alarm, falha);
    end
    s1 = -4'sd1;                  // pair 3 inverted so the resume point shows up
    ack = 1'b1;
    tick;
    ack = 1'b0;
    n_run++; if (alarm !== 1'b0 || dmp !== 6'd0) begin
      n_fail++; $display("FAIL alarm_ack alarm=%b dmp=%b exp=0/000000", alarm, dmp);
    end
    tick;
    n_run++; if (dmp !== 6'b001000) begin
      n_fail++; $display("FAIL alarm_resume got=%b exp=001000", dmp);
    end
  endtask

  task automatic test_signed;
    // S1=7, S2=-8: pair 3 healthy; pair 2 can only invert, so reach pair 3 via ack
    do_reset; healthy;
    s1 = 4'sd7; s2 = -4'sd8;
    for (int k = 0; k < 29; k++) tick;
    tick;
    n_run++; if (alarm !== 1'b1 || falha !== 3'd2) begin
      n_fail++; $display("FAIL signed_a_alarm alarm=%b falha=%0d exp=1/2", alarm, falha);
    end
    ack = 1'b1; tick; ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_run++; if (dmp !== 6'd0 || ocup !== 1'b0) begin
        n_fail++; $display("FAIL signed_pos_gt_neg step=%0d dmp=%b ocup=%b exp=000000/0", k, dmp, ocup);
      end
    end
    // S1=-8, S2=7: pair 3 inverted
    do_reset; healthy;
    s1 = -4'sd8; s2 = 4'sd7;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_run++; if (dmp !== ((k == 3) ? 6'b001000 : 6'b000000)) begin
        n_fail++; $display("FAIL signed_neg_lt_pos step=%0d got=%b exp=%b", k, dmp, (k == 3) ? 6'b001000 : 6'b000000);
      end
    end
  endtask

  task automatic test_rst_open;
    do_reset; healthy;
    sc = -4'sd2;                  // pair 5 equal -> inverted
    for (int k = 0; k < 5; k++) tick;
    n_run++; if (dmp !== 6'd0) begin n_fail++; $display("FAIL rstopen_prescan got=%b exp=000000", dmp); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_run++; if (dmp !== 6'b100000) begin
        n_fail++; $display("FAIL rstopen_open cyc=%0d got=%b exp=100000", k, dmp);
      end
    end
    rst = 1'b1;
    tick;
    n_run++; if (dmp !== 6'd0 || ocup !== 1'b0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL rstopen_close dmp=%b ocup=%b alarm=%b exp=000000/0/0", dmp, ocup, alarm);
    end
    rst = 1'b0; healthy;
    rea = -4'sd1; tsr = -4'sd2;   // pair 0 inverted: opens at once only if idx is 0
    tick;
    n_run++; if (dmp !== 6'b000001) begin
      n_fail++; $display("FAIL rstopen_idx0 got=%b exp=000001", dmp);
    end
  endtask

  task automatic test_rst_alarm;
    do_reset; healthy;
    s2 = -4'sd1; s3 = -4'sd1;
    for (int k = 0; k < 30; k++) tick;
    n_run++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL rstalarm_pre got=%b exp=1", alarm); end
    rst = 1'b1; ack = 1'b1;       // reset wins over the acknowledge
    tick;
    n_run++; if (alarm !== 1'b0 || falha !== 3'd0 || dmp !== 6'd0) begin
      n_fail++; $display("FAIL rstalarm_clear alarm=%b falha=%0d dmp=%b exp=0/0/000000", alarm, falha, dmp);
    end
    rst = 1'b0; ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0;
    healthy;
    test_reset;
    test_healthy;
    test_rsr_resolve;
    test_alarm;
    test_signed;
    test_rst_open;
    test_rst_alarm;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
